iccm_dump_tx: RTL and testbench

//  Readback path for the UART program loader: dumps NumWords words of ICCM over a serial UART line.

---
 rtl/iccm_dump_pkg.sv | 23 ++
 rtl/iccm_dump_tx_uart.sv | 99 +++++++++
 rtl/iccm_dump_tx.sv | 167 ++++++++++++++++
 tb/tb_iccm_dump_tx.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/iccm_dump_pkg.sv
// Shared types and constants for the ICCM readback (dump) path.
package iccm_dump_pkg;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WAIT,
        SEND,
        CSUM,
        FIN
    } ctrl_state_e;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_e;

    // Smallest usable bit period; smaller requests are clamped up to this.
    localparam int MinClksPerBit = 4;

endpackage

// File: rtl/iccm_dump_tx_uart.sv
// 8N1 byte serializer, LSB first, idle high.
// The final cycle of every stop bit is spent in TX_IDLE (line still high),
// so a byte offered at that point starts its start bit on the very next
// cycle: back-to-back frames have no idle gap and every bit is exactly
// bit_div cycles long. Requires bit_div >= 2 (the caller clamps to 4).
module uart_tx_byte
    import iccm_dump_pkg::*;
#(
    parameter int BaudWidth = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [BaudWidth-1:0] bit_div,
    input  logic                 byte_valid,
    output logic                 byte_ready,
    input  logic [7:0]           byte_data,
    output logic                 tx_o
);

    tx_state_e            state_q, state_d;
    logic [BaudWidth-1:0] baud_q, baud_d;
    logic [2:0]           bit_q, bit_d;
    logic [7:0]           shift_q, shift_d;
    logic                 bit_end;
    logic                 stop_end;

    assign bit_end  = (baud_q == bit_div - BaudWidth'(1));
    assign stop_end = (baud_q == bit_div - BaudWidth'(2));

    // Next-state, counters and line level for the current bit.
    always_comb begin
        state_d    = state_q;
        baud_d     = baud_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        byte_ready = 1'b0;
        tx_o       = 1'b1;
        case (state_q)
            TX_IDLE: begin
                byte_ready = 1'b1;
                if (byte_valid) begin
                    shift_d = byte_data;
                    baud_d  = '0;
                    state_d = TX_START;
                end
            end
            TX_START: begin
                tx_o = 1'b0;
                if (bit_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = TX_DATA;
                end else begin
                    baud_d = baud_q + BaudWidth'(1);
                end
            end
            TX_DATA: begin
                tx_o = shift_q[0];
                if (bit_end) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = TX_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + BaudWidth'(1);
                end
            end
            TX_STOP: begin
                // One cycle short: the remaining stop cycle is TX_IDLE.
                if (stop_end) begin
                    baud_d  = '0;
                    state_d = TX_IDLE;
                end else begin
                    baud_d = baud_q + BaudWidth'(1);
                end
            end
            default: state_d = TX_IDLE;
        endcase
    end

    // State and counter registers; reset forces the line high immediately.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= TX_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
        end
    end

endmodule

// File: rtl/iccm_dump_tx.sv
// ICCM readback: streams NumWords words starting at StartAddr over UART,
// least-significant byte first. Optional feature macro ICCM_DUMP_CSUM_EN
// appends one two's-complement checksum byte so the received stream sums
// to zero mod 256.
module iccm_dump_tx
    import iccm_dump_pkg::*;
#(
    parameter int                   AddrWidth = 12,
    parameter int                   DataWidth = 32,
    parameter int                   BaudWidth = 16,
    parameter logic [AddrWidth-1:0] StartAddr = '0
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic [AddrWidth-1:0] num_words_i,
    input  logic [BaudWidth-1:0] clks_per_bit_i,
    output logic                 mem_req_o,
    output logic [AddrWidth-1:0] mem_addr_o,
    input  logic [DataWidth-1:0] mem_rdata_i,
    output logic                 tx_o,
    output logic                 busy_o,
    output logic                 done_o
);

    localparam int BytesPerWord = DataWidth / 8;
    localparam int IdxW         = (BytesPerWord > 1) ? $clog2(BytesPerWord) : 1;

    ctrl_state_e          state_q, state_d;
    logic [AddrWidth-1:0] words_q, words_d;
    logic [AddrWidth-1:0] addr_q, addr_d;
    logic [BaudWidth-1:0] div_q, div_d;
    logic [DataWidth-1:0] word_q, word_d;
    logic [IdxW-1:0]      idx_q, idx_d;
    logic                 done_d;
`ifdef ICCM_DUMP_CSUM_EN
    logic [7:0]           sum_q, sum_d;
`endif

    logic                 byte_valid;
    logic                 byte_ready;
    logic [7:0]           byte_data;

    // Controller: fetch a word, hand its bytes out, prefetch the next word
    // while the last byte of the current one is still shifting.
    always_comb begin
        state_d    = state_q;
        words_d    = words_q;
        addr_d     = addr_q;
        div_d      = div_q;
        word_d     = word_q;
        idx_d      = idx_q;
        done_d     = 1'b0;
`ifdef ICCM_DUMP_CSUM_EN
        sum_d      = sum_q;
`endif
        mem_req_o  = 1'b0;
        byte_valid = 1'b0;
        byte_data  = word_q[{idx_q, 3'b000} +: 8];
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    words_d = num_words_i;
                    addr_d  = StartAddr;
                    div_d   = (clks_per_bit_i < BaudWidth'(MinClksPerBit)) ?
                              BaudWidth'(MinClksPerBit) : clks_per_bit_i;
`ifdef ICCM_DUMP_CSUM_EN
                    sum_d   = '0;
                    state_d = (num_words_i == '0) ? CSUM : READ;
`else
                    state_d = (num_words_i == '0) ? FIN : READ;
`endif
                end
            end
            READ: begin
                mem_req_o = 1'b1;
                state_d   = WAIT;
            end
            WAIT: begin
                word_d  = mem_rdata_i;
                idx_d   = '0;
                state_d = SEND;
            end
            SEND: begin
                byte_valid = 1'b1;
                if (byte_ready) begin
`ifdef ICCM_DUMP_CSUM_EN
                    sum_d = sum_q + byte_data;
`endif
                    if (idx_q == IdxW'(BytesPerWord - 1)) begin
                        words_d = words_q - AddrWidth'(1);
                        addr_d  = addr_q + AddrWidth'(1);
                        if (words_q == AddrWidth'(1)) begin
`ifdef ICCM_DUMP_CSUM_EN
                            state_d = CSUM;
`else
                            state_d = FIN;
`endif
                        end else begin
                            state_d = READ;
                        end
                    end else begin
                        idx_d = idx_q + IdxW'(1);
                    end
                end
            end
`ifdef ICCM_DUMP_CSUM_EN
            CSUM: begin
                byte_valid = 1'b1;
                byte_data  = ~sum_q + 8'd1;
                if (byte_ready) state_d = FIN;
            end
`endif
            FIN: begin
                // TX idle means the last stop bit is in its final cycle.
                if (byte_ready) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Controller registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            words_q <= '0;
            addr_q  <= StartAddr;
            div_q   <= '0;
            word_q  <= '0;
            idx_q   <= '0;
            done_o  <= 1'b0;
`ifdef ICCM_DUMP_CSUM_EN
            sum_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            words_q <= words_d;
            addr_q  <= addr_d;
            div_q   <= div_d;
            word_q  <= word_d;
            idx_q   <= idx_d;
            done_o  <= done_d;
`ifdef ICCM_DUMP_CSUM_EN
            sum_q   <= sum_d;
`endif
        end
    end

    assign mem_addr_o = addr_q;
    assign busy_o     = (state_q != IDLE);

    uart_tx_byte #(
        .BaudWidth(BaudWidth)
    ) u_tx (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .bit_div    (div_q),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .byte_data  (byte_data),
        .tx_o       (tx_o)
    );

endmodule

// File: tb/tb_iccm_dump_tx.sv
// Bench for iccm_dump_tx: an ideal line waveform is derived from the memory
// image and the frame rules, compared against tx_o/busy_o/done_o each cycle,
// and the captured line is also decoded as a UART receiver would.
module tb_iccm_dump_tx;

    localparam int AW = 12;
    localparam int DW = 32;
    localparam int BW = 16;
`ifdef ICCM_DUMP_CSUM_EN
    localparam int NCS = 1;
`else
    localparam int NCS = 0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] num_words = '0;
    logic [BW-1:0] cpb = 16'd8;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rdata = '0;
    logic          tx, busy, done;

    iccm_dump_tx #(.AddrWidth(AW), .DataWidth(DW), .BaudWidth(BW)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .start_i        (start),
        .num_words_i    (num_words),
        .clks_per_bit_i (cpb),
        .mem_req_o      (mem_req),
        .mem_addr_o     (mem_addr),
        .mem_rdata_i    (mem_rdata),
        .tx_o           (tx),
        .busy_o         (busy),
        .done_o         (done)
    );

    always #5 clk = ~clk;

    // ICCM model: data one cycle after the read strobe.
    logic [DW-1:0] mem [0:4095];
    always @(posedge clk) if (mem_req) mem_rdata <= mem[mem_addr];

    int         nvec = 0;
    int         nerr = 0;
    logic [7:0] exp_q[$];
    logic [7:0] rx_q[$];
    logic       cap[$];
    logic [AW-1:0] req_q[$];
    int         dpos_g;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            if (nerr <= 40) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Ideal line level i cycles after the accepted start pulse.
    function automatic logic exp_tx(input int i, input int bd, input int n);
        int off, b, p;
        if (i < 4 || i >= 4 + 10 * bd * n) return 1'b1;
        off = i - 4;
        b   = off / (10 * bd);
        p   = (off % (10 * bd)) / bd;
        if (p == 0) return 1'b0;
        if (p == 9) return 1'b1;
        return exp_q[b][p-1];
    endfunction

    function automatic logic [7:0] rxat(input int k);
        if (rx_q.size() > k) return rx_q[k];
        return 8'hxx;
    endfunction

    // Receiver view of the captured line: sample each bit mid-period.
    task automatic decode(input int bd);
        int i, idx;
        logic [7:0] v;
        rx_q.delete();
        i = 0;
        while (i < cap.size()) begin
            if (cap[i] == 1'b0) begin
                for (int k = 0; k < 8; k++) begin
                    idx  = i + bd * (k + 1) + bd / 2;
                    v[k] = (idx < cap.size()) ? cap[idx] : 1'b1;
                end
                rx_q.push_back(v);
                i += 10 * bd;
            end else begin
                i++;
            end
        end
    endtask

    // One dump; poke>0 pulses start with other config at that cycle.
    task automatic run_dump(input int nw, input int cp, input int poke);
        int bd, n, dc, last, dones, dpos;
        logic [DW-1:0] w;
        logic [7:0] s;
        bd = (cp < 4) ? 4 : cp;
        s  = 8'h00;
        exp_q.delete();
        for (int k = 0; k < nw; k++) begin
            w = mem[k % 4096];
            for (int b = 0; b < 4; b++) begin
                exp_q.push_back(w[8*b +: 8]);
                s = s + w[8*b +: 8];
            end
        end
        if (NCS == 1) exp_q.push_back(8'h00 - s);
        n     = exp_q.size();
        dc    = (n > 0) ? 4 + 10 * bd * n : 0;
        last  = (n > 0) ? dc + 2 : 6;
        dones = 0;
        dpos  = 0;
        req_q.delete();
        cap.delete();
        @(negedge clk);
        num_words = AW'(nw);
        cpb       = BW'(cp);
        start     = 1'b1;
        for (int i = 1; i <= last; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (i == poke) begin
                start     = 1'b1;
                num_words = AW'(5);
                cpb       = BW'(1);
            end
            cap.push_back(tx);
            if (mem_req) req_q.push_back(mem_addr);
            chk("tx", tx, exp_tx(i, bd, n));
            if (done) begin
                dones++;
                dpos = i;
            end
            if (n > 0) begin
                chk("busy", busy, i < dc);
                chk("done", done, i == dc);
            end
        end
        start = 1'b0;
        chk("done_count", dones, 1);
        if (n == 0) chk("done_early", dpos >= 1 && dpos <= 3, 1);
        chk("req_count", req_q.size(), nw);
        for (int k = 0; k < req_q.size(); k++) chk("req_addr", req_q[k], AW'(k));
        decode(bd);
        chk("rx_count", rx_q.size(), n);
        for (int k = 0; k < n; k++) chk("rx_byte", rxat(k), exp_q[k]);
        dpos_g = dpos;
    endtask

    initial begin
        int sum;
        mem[0] = 32'h1234_5678;
        mem[1] = 32'h00FF_00FF;
        mem[2] = 32'hDEAD_BEEF;
        mem[3] = 32'h0;

        // Reset state and quiet line.
        #1;
        chk("rst_tx", tx, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_req", mem_req, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_addr", mem_addr, '0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            chk("idle_tx", tx, 1'b1);
            chk("idle_busy", busy, 1'b0);
        end

        // Single word at 8 clocks per bit.
        run_dump(1, 8, 0);
        chk("t2_b0", rxat(0), 8'h78);
        chk("t2_b1", rxat(1), 8'h56);
        chk("t2_b2", rxat(2), 8'h34);
        chk("t2_b3", rxat(3), 8'h12);
        chk("t2_done_pos", dpos_g, 324 + NCS * 80);

        // Streaming three words at the minimum bit period.
        mem[0] = 32'hA5A5_A5A5;
        run_dump(3, 4, 0);
        chk("t3_b0", rxat(0), 8'hA5);
        chk("t3_b4", rxat(4), 8'hFF);
        chk("t3_b5", rxat(5), 8'h00);
        chk("t3_b8", rxat(8), 8'hEF);
        chk("t3_b11", rxat(11), 8'hDE);
        chk("t3_done_pos", dpos_g, 484 + NCS * 40);

        // Edge configurations.
        run_dump(0, 8, 0);
        run_dump(1, 1, 0);
        chk("t4_clamp_done", dpos_g, 164 + NCS * 40);
        run_dump(2, 4, 50);

        // Reset during data bit 3 of byte 0xF0 (bit 3 is low).
        mem[0] = 32'h0000_00F0;
        @(negedge clk);
        num_words = AW'(1);
        cpb       = BW'(8);
        start     = 1'b1;
        for (int i = 1; i <= 39; i++) begin
            @(negedge clk);
            start = 1'b0;
        end
        chk("pre_rst_tx", tx, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_tx", tx, 1'b1);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_req", mem_req, 1'b0);
        @(negedge clk);
        rst_n  = 1'b1;
        mem[0] = 32'h1234_5678;
        run_dump(2, 5, 0);

`ifdef ICCM_DUMP_CSUM_EN
        mem[0] = 32'h0403_0201;
        run_dump(1, 4, 0);
        chk("t6_b0", rxat(0), 8'h01);
        chk("t6_b3", rxat(3), 8'h04);
        chk("t6_csum", rxat(4), 8'hF6);
        sum = 0;
        for (int k = 0; k < rx_q.size(); k++) sum += rx_q[k];
        chk("t6_sum", sum % 256, 0);
`else
        sum = 0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
